// File: rtl/udp_rx_pkg.sv
// Shared constants and FSM state encoding for the GMII UDP/IPv4 receiver.
package udp_rx_pkg;

    localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_PROTO_UDP  = 8'd17;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [15:0] ETH_HEAD_LEN  = 16'd14;
    localparam logic [15:0] UDP_HEAD_LEN  = 16'd8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_ETH_HEAD = 3'd2,
        ST_IP_HEAD  = 3'd3,
        ST_UDP_HEAD = 3'd4,
        ST_RX_DATA  = 3'd5,
        ST_RX_END   = 3'd6
    } state_t;

endpackage

// File: rtl/udp_rx.sv
// GMII-side UDP/IPv4 receiver: strips preamble/SFD and Ethernet/IPv4/UDP
// headers, filters on board MAC/IP, streams the UDP payload out.
module udp_rx
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123}
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        rec_en,
    output logic [7:0]  rec_data,
    output logic [15:0] rec_byte_num,
    output logic        rec_pkt_done,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);

    localparam logic [47:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

    state_t      state_r;
    state_t      next_s;
    logic        dv_r;
    logic [7:0]  rxd_r;
    logic        armed_r;        // set once dv has been seen low after reset
    logic [15:0] cnt_r;
    logic [39:0] dst_mac_r;
    logic [47:0] src_mac_sh_r;
    logic [7:0]  eth_type_hi_r;
    logic [3:0]  ihl_r;
    logic [31:0] src_ip_sh_r;
    logic [23:0] dst_ip_r;
    logic [15:0] udp_len_r;
    logic [15:0] data_num_r;

    logic        emit_s;
    logic        done_s;
    logic [15:0] done_num_s;
    logic        dst_ok_s;
    logic [15:0] hdr_last_s;

    assign dst_ok_s   = ({dst_mac_r, rxd_r} == BOARD_MAC) || ({dst_mac_r, rxd_r} == BCAST_MAC);
    assign hdr_last_s = {10'd0, ihl_r, 2'b00} - 16'd1;

    // Register the GMII inputs once; track whether a dv-low gap has been seen since reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_r    <= 1'b0;
            rxd_r   <= 8'd0;
            armed_r <= 1'b0;
        end else begin
            dv_r    <= gmii_rx_dv;
            rxd_r   <= gmii_rxd;
            armed_r <= armed_r | ~gmii_rx_dv;
        end
    end

    // Next-state decode and payload/done strobes.
    always_comb begin
        next_s     = state_r;
        emit_s     = 1'b0;
        done_s     = 1'b0;
        done_num_s = data_num_r;
        case (state_r)
            ST_IDLE: begin
                if (dv_r && armed_r && (rxd_r == PREAMBLE_BYTE)) begin
                    next_s = ST_PREAMBLE;
                end else begin
                    next_s = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (!dv_r) begin
                    next_s = ST_IDLE;
                end else if (rxd_r == PREAMBLE_BYTE) begin
                    if (cnt_r >= 16'd7) begin
                        next_s = ST_RX_END;
                    end else begin
                        next_s = ST_PREAMBLE;
                    end
                end else if ((rxd_r == SFD_BYTE) && ((cnt_r == 16'd6) || (cnt_r == 16'd7))) begin
                    next_s = ST_ETH_HEAD;
                end else begin
                    next_s = ST_RX_END;
                end
            end
            ST_ETH_HEAD: begin
                if (!dv_r) begin
                    next_s = ST_IDLE;
                end else if ((cnt_r == 16'd5) && !dst_ok_s) begin
                    next_s = ST_RX_END;
                end else if (cnt_r == ETH_HEAD_LEN - 16'd1) begin
                    if ({eth_type_hi_r, rxd_r} == ETH_TYPE_IPV4) begin
                        next_s = ST_IP_HEAD;
                    end else begin
                        next_s = ST_RX_END;
                    end
                end else begin
                    next_s = ST_ETH_HEAD;
                end
            end
            ST_IP_HEAD: begin
                if (!dv_r) begin
                    next_s = ST_IDLE;
                end else if ((cnt_r == 16'd0) && ((rxd_r[7:4] != 4'd4) || (rxd_r[3:0] < 4'd5))) begin
                    next_s = ST_RX_END;
                end else if ((cnt_r == 16'd9) && (rxd_r != IP_PROTO_UDP)) begin
                    next_s = ST_RX_END;
                end else if ((cnt_r == 16'd19) && ({dst_ip_r, rxd_r} != BOARD_IP)) begin
                    next_s = ST_RX_END;
                end else if ((cnt_r >= 16'd19) && (cnt_r == hdr_last_s)) begin
                    next_s = ST_UDP_HEAD;
                end else begin
                    next_s = ST_IP_HEAD;
                end
            end
            ST_UDP_HEAD: begin
                if (!dv_r) begin
                    next_s = ST_IDLE;
                end else if ((cnt_r == 16'd5) && ({udp_len_r[15:8], rxd_r} < UDP_HEAD_LEN)) begin
                    next_s = ST_RX_END;
                end else if (cnt_r == UDP_HEAD_LEN - 16'd1) begin
                    if (udp_len_r == UDP_HEAD_LEN) begin
                        done_s     = 1'b1;
                        done_num_s = 16'd0;
                        next_s     = ST_RX_END;
                    end else begin
                        next_s = ST_RX_DATA;
                    end
                end else begin
                    next_s = ST_UDP_HEAD;
                end
            end
            ST_RX_DATA: begin
                if (!dv_r) begin
                    next_s = ST_IDLE;
                end else begin
                    emit_s = 1'b1;
                    if (cnt_r == data_num_r - 16'd1) begin
                        done_s = 1'b1;
                        next_s = ST_RX_END;
                    end else begin
                        next_s = ST_RX_DATA;
                    end
                end
            end
            ST_RX_END: begin
                if (!dv_r) begin
                    next_s = ST_IDLE;
                end else begin
                    next_s = ST_RX_END;
                end
            end
            default: begin
                next_s = ST_IDLE;
            end
        endcase
    end

    // State register and per-state byte counter (cleared on every state change).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
        end else begin
            state_r <= next_s;
            if (next_s != state_r) begin
                cnt_r <= (next_s == ST_PREAMBLE) ? 16'd1 : 16'd0;
            end else if (dv_r && (state_r != ST_IDLE)) begin
                cnt_r <= cnt_r + 16'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Capture header fields into shadow registers as their bytes go by.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dst_mac_r     <= 40'd0;
            src_mac_sh_r  <= 48'd0;
            eth_type_hi_r <= 8'd0;
            ihl_r         <= 4'd0;
            src_ip_sh_r   <= 32'd0;
            dst_ip_r      <= 24'd0;
            udp_len_r     <= 16'd0;
            data_num_r    <= 16'd0;
        end else if (dv_r) begin
            case (state_r)
                ST_ETH_HEAD: begin
                    if (cnt_r < 16'd5) begin
                        dst_mac_r <= {dst_mac_r[31:0], rxd_r};
                    end else if ((cnt_r >= 16'd6) && (cnt_r <= 16'd11)) begin
                        src_mac_sh_r <= {src_mac_sh_r[39:0], rxd_r};
                    end else if (cnt_r == 16'd12) begin
                        eth_type_hi_r <= rxd_r;
                    end else begin
                        eth_type_hi_r <= eth_type_hi_r;
                    end
                end
                ST_IP_HEAD: begin
                    if (cnt_r == 16'd0) begin
                        ihl_r <= rxd_r[3:0];
                    end else if ((cnt_r >= 16'd12) && (cnt_r <= 16'd15)) begin
                        src_ip_sh_r <= {src_ip_sh_r[23:0], rxd_r};
                    end else if ((cnt_r >= 16'd16) && (cnt_r <= 16'd18)) begin
                        dst_ip_r <= {dst_ip_r[15:0], rxd_r};
                    end else begin
                        ihl_r <= ihl_r;
                    end
                end
                ST_UDP_HEAD: begin
                    if (cnt_r == 16'd4) begin
                        udp_len_r[15:8] <= rxd_r;
                    end else if (cnt_r == 16'd5) begin
                        udp_len_r[7:0] <= rxd_r;
                    end else if (cnt_r == UDP_HEAD_LEN - 16'd1) begin
                        data_num_r <= udp_len_r - UDP_HEAD_LEN;
                    end else begin
                        udp_len_r <= udp_len_r;
                    end
                end
                default: begin
                    data_num_r <= data_num_r;
                end
            endcase
        end else begin
            data_num_r <= data_num_r;
        end
    end

    // Registered user-side outputs; packet results latch only on completion.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_en       <= 1'b0;
            rec_data     <= 8'd0;
            rec_pkt_done <= 1'b0;
            rec_byte_num <= 16'd0;
            src_mac      <= 48'd0;
            src_ip       <= 32'd0;
        end else begin
            rec_en       <= emit_s;
            rec_data     <= emit_s ? rxd_r : rec_data;
            rec_pkt_done <= done_s;
            if (done_s) begin
                rec_byte_num <= done_num_s;
                src_mac      <= src_mac_sh_r;
                src_ip       <= src_ip_sh_r;
            end else begin
                rec_byte_num <= rec_byte_num;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx.sv
// Self-checking bench for udp_rx: directed vector table, reset corner case,
// and random frames checked against a byte-level frame parser model.
module tb_udp_rx;

    localparam logic [47:0] BOARD_MAC = 48'h00_11_22_33_44_55;
    localparam logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd123};
    localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        rec_en;
    logic [7:0]  rec_data;
    logic [15:0] rec_byte_num;
    logic        rec_pkt_done;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    udp_rx dut (
        .clk(clk), .rst(rst), .gmii_rx_dv(gmii_rx_dv), .gmii_rxd(gmii_rxd),
        .rec_en(rec_en), .rec_data(rec_data), .rec_byte_num(rec_byte_num),
        .rec_pkt_done(rec_pkt_done), .src_mac(src_mac), .src_ip(src_ip)
    );

    always #4 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0]  frm[$];
    logic [7:0]  exp_q[$];
    bit          exp_done;
    logic [7:0]  got_q[$];
    int          done_cnt;
    logic        done_en;
    logic [7:0]  done_data;
    logic [47:0] cur_smac;
    logic [31:0] cur_sip;
    logic [15:0] mdl_num;
    logic [47:0] mdl_mac;
    logic [31:0] mdl_ip;

    typedef struct {
        string       nm;
        int          npre;
        logic [47:0] dst;
        logic [7:0]  vh;
        logic [7:0]  proto;
        logic [31:0] dip;
        logic [15:0] ulen;
        int          npay;
        logic [7:0]  pbase;
        logic [7:0]  pstep;
        int          cut;
        int          exp_en;
        bit          exp_done;
        logic [15:0] exp_num;
    } vec_t;

    vec_t vec_q[$];

    // Capture the output stream away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rec_en) got_q.push_back(rec_data);
            if (rec_pkt_done) begin
                done_cnt  = done_cnt + 1;
                done_en   = rec_en;
                done_data = rec_data;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    task automatic build(input int npre, input logic [47:0] dst, input logic [15:0] et,
                         input logic [7:0] vh, input logic [7:0] proto, input logic [31:0] dip,
                         input logic [15:0] ulen, input int npay, input logic [7:0] pbase,
                         input logic [7:0] pstep, input bit rnd, input int npad);
        int nopt;
        frm.delete();
        for (int k = 0; k < npre; k++) frm.push_back(8'h55);
        frm.push_back(8'hD5);
        for (int k = 0; k < 6; k++) frm.push_back(dst[47-8*k -: 8]);
        for (int k = 0; k < 6; k++) frm.push_back(cur_smac[47-8*k -: 8]);
        frm.push_back(et[15:8]); frm.push_back(et[7:0]);
        frm.push_back(vh); frm.push_back(8'h00);
        frm.push_back(8'h00); frm.push_back(8'h30);
        frm.push_back(8'h12); frm.push_back(8'h34);
        frm.push_back(8'h40); frm.push_back(8'h00);
        frm.push_back(8'h40); frm.push_back(proto);
        frm.push_back(8'hBE); frm.push_back(8'hEF);
        for (int k = 0; k < 4; k++) frm.push_back(cur_sip[31-8*k -: 8]);
        for (int k = 0; k < 4; k++) frm.push_back(dip[31-8*k -: 8]);
        nopt = (vh[3:0] >= 4'd5) ? (int'(vh[3:0]) * 4 - 20) : 0;
        for (int k = 0; k < nopt; k++) frm.push_back(8'h5A);
        frm.push_back(8'h13); frm.push_back(8'h88);
        frm.push_back(8'h17); frm.push_back(8'h70);
        frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
        frm.push_back(8'h00); frm.push_back(8'h00);
        for (int k = 0; k < npay; k++)
            frm.push_back(rnd ? 8'($urandom_range(0, 255)) : 8'(pbase + 8'(k) * pstep));
        for (int k = 0; k < npad; k++) frm.push_back(8'($urandom_range(0, 255)));
    endtask

    // Reference parser: walks the first L bytes of the frame by protocol rules.
    task automatic model(input int L);
        int n, e, i, hl, u, p;
        logic [47:0] d;
        logic [31:0] ip, sip;
        logic [15:0] ulen, dn;
        logic [47:0] smac;
        exp_q.delete();
        exp_done = 1'b0;
        n = 0;
        while (n < L && frm[n] == 8'h55) n++;
        if (n < 6 || n > 7 || n >= L || frm[n] != 8'hD5) return;
        e = n + 1;
        if (L < e + 14) return;
        d = 48'd0; smac = 48'd0;
        for (int k = 0; k < 6; k++) d = {d[39:0], frm[e+k]};
        for (int k = 0; k < 6; k++) smac = {smac[39:0], frm[e+6+k]};
        if (d != BOARD_MAC && d != BCAST) return;
        if ({frm[e+12], frm[e+13]} != 16'h0800) return;
        i = e + 14;
        if (L <= i) return;
        if (frm[i][7:4] != 4'd4 || frm[i][3:0] < 4'd5) return;
        hl = int'(frm[i][3:0]) * 4;
        if (L < i + hl) return;
        if (frm[i+9] != 8'd17) return;
        ip = 32'd0; sip = 32'd0;
        for (int k = 0; k < 4; k++) sip = {sip[23:0], frm[i+12+k]};
        for (int k = 0; k < 4; k++) ip = {ip[23:0], frm[i+16+k]};
        if (ip != BOARD_IP) return;
        u = i + hl;
        if (L < u + 8) return;
        ulen = {frm[u+4], frm[u+5]};
        if (ulen < 16'd8) return;
        dn = ulen - 16'd8;
        p = u + 8;
        for (int k = 0; k < int'(dn) && p + k < L; k++) exp_q.push_back(frm[p+k]);
        if (L >= p + int'(dn)) begin
            exp_done = 1'b1;
            mdl_num = dn; mdl_mac = smac; mdl_ip = sip;
        end
    endtask

    task automatic drive(input int L);
        got_q.delete(); done_cnt = 0; done_en = 1'b0; done_data = 8'd0;
        for (int k = 0; k < L; k++) begin
            @(posedge clk); #1;
            gmii_rx_dv = 1'b1; gmii_rxd = frm[k];
        end
        @(posedge clk); #1;
        gmii_rx_dv = 1'b0; gmii_rxd = 8'd0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic chk_frame(input string nm);
        int bad, m;
        chk({nm, ".en_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        bad = 0;
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < m; k++) if (got_q[k] !== exp_q[k]) bad++;
        chk({nm, ".data_errs"}, 64'(bad), 64'd0);
        chk({nm, ".done_count"}, 64'(done_cnt), 64'(exp_done));
        if (exp_done && exp_q.size() > 0) begin
            chk({nm, ".done_with_last_en"}, {63'd0, done_en}, 64'd1);
            chk({nm, ".done_last_data"}, 64'(done_data), 64'(exp_q[exp_q.size()-1]));
        end
        chk({nm, ".byte_num"}, 64'(rec_byte_num), 64'(mdl_num));
        chk({nm, ".src_mac"}, 64'(src_mac), 64'(mdl_mac));
        chk({nm, ".src_ip"}, 64'(src_ip), 64'(mdl_ip));
    endtask

    task automatic add(input string nm, input int npre, input logic [47:0] dst, input logic [7:0] vh,
                       input logic [7:0] proto, input logic [31:0] dip, input logic [15:0] ulen,
                       input int npay, input logic [7:0] pbase, input logic [7:0] pstep, input int cut,
                       input int exp_en, input bit exp_done_v, input logic [15:0] exp_num);
        vec_t v;
        v = '{nm, npre, dst, vh, proto, dip, ulen, npay, pbase, pstep, cut, exp_en, exp_done_v, exp_num};
        vec_q.push_back(v);
    endtask

    initial begin
        logic [7:0] seq[$];
        int L, sel;
        logic [47:0] dst;
        logic [15:0] et, ulen;
        logic [7:0]  vh, proto;
        logic [31:0] dip;
        int npre, npay;

        rst = 1'b1; gmii_rx_dv = 1'b0; gmii_rxd = 8'd0;
        mdl_num = 16'd0; mdl_mac = 48'd0; mdl_ip = 32'd0;
        #10 rst = 1'b0;
        @(posedge clk); #1;
        chk("reset.rec_en", 64'(rec_en), 64'd0);
        chk("reset.rec_pkt_done", 64'(rec_pkt_done), 64'd0);
        chk("reset.rec_byte_num", 64'(rec_byte_num), 64'd0);
        chk("reset.src_mac_ip", {src_mac[31:0], src_ip}, 64'd0);

        //   name          pre dst                      vh     proto  dip                         ulen    npay pbase  step   cut exp_en done num
        add("basic",       7, BOARD_MAC,               8'h45, 8'd17, BOARD_IP,                   16'd12, 4, 8'h01, 8'h01, -1, 4, 1, 16'd4);
        add("bcast",       7, BCAST,                   8'h45, 8'd17, BOARD_IP,                   16'd12, 4, 8'h21, 8'h01, -1, 4, 1, 16'd4);
        add("bad_ip",      7, BOARD_MAC,               8'h45, 8'd17, {8'd192,8'd168,8'd1,8'd124}, 16'd12, 4, 8'h31, 8'h01, -1, 0, 0, 16'd4);
        add("proto_tcp",   7, BOARD_MAC,               8'h45, 8'd6,  BOARD_IP,                   16'd12, 4, 8'h41, 8'h01, -1, 0, 0, 16'd4);
        add("ihl6",        7, BOARD_MAC,               8'h46, 8'd17, BOARD_IP,                   16'd10, 2, 8'hAA, 8'h11, -1, 2, 1, 16'd2);
        add("len8",        7, BOARD_MAC,               8'h45, 8'd17, BOARD_IP,                   16'd8,  0, 8'h00, 8'h01, -1, 0, 1, 16'd0);
        add("len5",        7, BOARD_MAC,               8'h45, 8'd17, BOARD_IP,                   16'd5,  0, 8'h00, 8'h01, -1, 0, 0, 16'd0);
        add("pre6",        6, BOARD_MAC,               8'h45, 8'd17, BOARD_IP,                   16'd11, 3, 8'h71, 8'h01, -1, 3, 1, 16'd3);
        add("dv_drop",     7, BOARD_MAC,               8'h45, 8'd17, BOARD_IP,                   16'd12, 4, 8'h81, 8'h01, 52, 2, 0, 16'd3);
        add("after_drop",  7, BOARD_MAC,               8'h45, 8'd17, BOARD_IP,                   16'd12, 4, 8'h91, 8'h01, -1, 4, 1, 16'd4);
        add("bad_mac",     7, 48'h00_11_22_33_44_56,   8'h45, 8'd17, BOARD_IP,                   16'd12, 4, 8'hA1, 8'h01, -1, 0, 0, 16'd4);
        add("pre8",        8, BOARD_MAC,               8'h45, 8'd17, BOARD_IP,                   16'd12, 4, 8'hB1, 8'h01, -1, 0, 0, 16'd4);

        foreach (vec_q[vi]) begin
            cur_smac = 48'h02_00_00_00_10_00 + 48'(vi);
            cur_sip  = {8'd10, 8'd0, 8'd0, 8'(vi + 1)};
            build(vec_q[vi].npre, vec_q[vi].dst, 16'h0800, vec_q[vi].vh, vec_q[vi].proto,
                  vec_q[vi].dip, vec_q[vi].ulen, vec_q[vi].npay, vec_q[vi].pbase,
                  vec_q[vi].pstep, 1'b0, 22);
            L = (vec_q[vi].cut < 0) ? frm.size() : vec_q[vi].cut;
            drive(L);
            model(L);
            chk({vec_q[vi].nm, ".tbl_en"}, 64'(got_q.size()), 64'(vec_q[vi].exp_en));
            chk({vec_q[vi].nm, ".tbl_done"}, 64'(done_cnt), 64'(vec_q[vi].exp_done));
            chk({vec_q[vi].nm, ".tbl_num"}, 64'(rec_byte_num), 64'(vec_q[vi].exp_num));
            if (vec_q[vi].exp_done)
                chk({vec_q[vi].nm, ".tbl_src_mac"}, 64'(src_mac), 64'(cur_smac));
            chk_frame(vec_q[vi].nm);
        end

        // Reset mid-payload, released while a second frame is already on the wire.
        cur_smac = 48'h02_00_00_00_20_00; cur_sip = {8'd10, 8'd1, 8'd0, 8'd1};
        build(7, BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, 16'd18, 10, 8'h01, 8'h01, 1'b0, 0);
        seq = frm[0:51];
        build(7, BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, 16'd12, 4, 8'hC1, 8'h01, 1'b0, 10);
        foreach (frm[k]) seq.push_back(frm[k]);
        for (int k = 0; k < seq.size(); k++) begin
            @(posedge clk); #1;
            gmii_rx_dv = 1'b1; gmii_rxd = seq[k];
            if (k == 52) begin
                #2 rst = 1'b1;
                #1;
                chk("rst.rec_en", 64'(rec_en), 64'd0);
                chk("rst.rec_data", 64'(rec_data), 64'd0);
                chk("rst.rec_byte_num", 64'(rec_byte_num), 64'd0);
                chk("rst.src_mac", 64'(src_mac), 64'd0);
                chk("rst.src_ip", 64'(src_ip), 64'd0);
            end
            if (k == 53) begin
                rst = 1'b0;
                got_q.delete(); done_cnt = 0;
            end
        end
        @(posedge clk); #1;
        gmii_rx_dv = 1'b0; gmii_rxd = 8'd0;
        repeat (8) @(posedge clk);
        #1;
        chk("rst.inflight_en", 64'(got_q.size()), 64'd0);
        chk("rst.inflight_done", 64'(done_cnt), 64'd0);
        mdl_num = 16'd0; mdl_mac = 48'd0; mdl_ip = 32'd0;
        cur_smac = 48'h02_00_00_00_30_00; cur_sip = {8'd10, 8'd2, 8'd0, 8'd1};
        build(7, BOARD_MAC, 16'h0800, 8'h45, 8'd17, BOARD_IP, 16'd12, 4, 8'hD1, 8'h01, 1'b0, 10);
        drive(frm.size());
        model(frm.size());
        chk("rst.next_en", 64'(got_q.size()), 64'd4);
        chk_frame("rst.next");

        // Random frames against the reference parser.
        for (int r = 0; r < 150; r++) begin
            cur_smac = {16'h0200, 32'($urandom)};
            cur_sip  = 32'($urandom);
            sel   = $urandom_range(0, 19);
            npre  = (sel == 0) ? 5 : (sel == 1) ? 8 : $urandom_range(6, 7);
            dst   = (sel == 2) ? {16'h0000, 32'($urandom)} : (sel < 8) ? BCAST : BOARD_MAC;
            et    = (sel == 3) ? 16'h86DD : 16'h0800;
            vh    = (sel == 4) ? 8'h44 : (sel == 5) ? 8'h55 : {4'h4, 4'($urandom_range(5, 7))};
            proto = (sel == 6) ? 8'd6 : 8'd17;
            dip   = (sel == 7) ? 32'($urandom) : BOARD_IP;
            npay  = $urandom_range(0, 12);
            ulen  = (sel == 8) ? 16'($urandom_range(0, 7)) :
                    (sel == 9) ? 16'(8 + npay + $urandom_range(1, 6)) : 16'(8 + npay);
            build(npre, dst, et, vh, proto, dip, ulen, npay, 8'h00, 8'h01, 1'b1, $urandom_range(0, 20));
            L = ($urandom_range(0, 4) == 0) ? $urandom_range(1, frm.size()) : frm.size();
            drive(L);
            model(L);
            chk_frame($sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
